// File: rtl/rx_prbs_checker.sv
// Receive-side PRBS checker: seeds from the incoming stream, locks after a run of matching words,
// then checks each beat against a free-running local LFSR and keeps saturating error statistics.
module rx_prbs_checker #(
    parameter logic [31:0] C_PRBS_POLY     = 32'h8020_0003,
    parameter int unsigned C_LOCK_COUNT    = 4,
    parameter int unsigned C_UNLOCK_ERRORS = 8
) (
    input  logic        i_aclk,
    input  logic        i_reset,
    input  logic        i_rx_enable,
    input  logic        i_clear_counters,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_sof,
    input  logic [31:0] s_axis_tdata,
    output logic        o_locked,
    output logic        o_lock_lost,
    output logic [31:0] o_word_count,
    output logic [31:0] o_err_word_count,
    output logic [31:0] o_bit_err_count,
    output logic [31:0] o_lock_loss_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_LOCKED} state_t;

    localparam logic [7:0] LOCK_LAST   = 8'(C_LOCK_COUNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(C_UNLOCK_ERRORS - 1);

    state_t      state_q;
    logic [31:0] expected_q;
    logic        have_seed_q;
    logic [7:0]  match_cnt_q;
    logic [7:0]  consec_err_q;
    logic        lost_q;
    logic [31:0] word_q, err_q, bit_q, loss_q;
    logic [31:0] xor_q;
    logic        xor_vld_q;

    logic        beat;
    logic        match;
    logic [32:0] bit_sum;
    logic [31:0] bit_d;

    function automatic logic [31:0] prbs_next(input logic [31:0] w);
        return {w[30:0], 1'b0} ^ (w[31] ? C_PRBS_POLY : 32'h0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    assign s_axis_tready = i_rx_enable;
    assign beat          = s_axis_tvalid & i_rx_enable;
    assign match         = (s_axis_tdata == expected_q);

    // Second pipeline stage: popcount of the registered XOR, clamped to all-ones.
    assign bit_sum = {1'b0, bit_q} + {27'd0, popcount32(xor_q)};
    assign bit_d   = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            expected_q   <= 32'd0;
            have_seed_q  <= 1'b0;
            match_cnt_q  <= 8'd0;
            consec_err_q <= 8'd0;
            lost_q       <= 1'b0;
            word_q       <= 32'd0;
            err_q        <= 32'd0;
            bit_q        <= 32'd0;
            loss_q       <= 32'd0;
            xor_q        <= 32'd0;
            xor_vld_q    <= 1'b0;
        end else begin
            lost_q    <= 1'b0;
            xor_vld_q <= 1'b0;
            if (xor_vld_q) bit_q <= bit_d;

            if (!i_rx_enable) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q     <= ST_SEARCH;
                        have_seed_q <= 1'b0;
                        match_cnt_q <= 8'd0;
                    end
                    ST_SEARCH, ST_LOCKED: begin
                        if (beat) begin
                            if (s_axis_sof) begin
                                // Frame start always reseeds; it is not an error and not a lock loss.
                                state_q     <= ST_SEARCH;
                                expected_q  <= prbs_next(s_axis_tdata);
                                have_seed_q <= 1'b1;
                                match_cnt_q <= 8'd0;
                            end else if (state_q == ST_SEARCH) begin
                                expected_q <= prbs_next(s_axis_tdata);
                                if (!have_seed_q) begin
                                    have_seed_q <= 1'b1;
                                    match_cnt_q <= 8'd0;
                                end else if (!match) begin
                                    match_cnt_q <= 8'd0;
                                end else if (match_cnt_q == LOCK_LAST) begin
                                    state_q      <= ST_LOCKED;
                                    match_cnt_q  <= 8'd0;
                                    consec_err_q <= 8'd0;
                                end else begin
                                    match_cnt_q <= match_cnt_q + 8'd1;
                                end
                            end else begin
                                // Free-running reference: a corrupt word costs exactly one error.
                                expected_q <= prbs_next(expected_q);
                                word_q     <= sat_inc(word_q);
                                if (!match) begin
                                    err_q     <= sat_inc(err_q);
                                    xor_q     <= s_axis_tdata ^ expected_q;
                                    xor_vld_q <= 1'b1;
                                    if (consec_err_q == UNLOCK_LAST) begin
                                        state_q      <= ST_SEARCH;
                                        have_seed_q  <= 1'b0;
                                        match_cnt_q  <= 8'd0;
                                        consec_err_q <= 8'd0;
                                        lost_q       <= 1'b1;
                                        loss_q       <= sat_inc(loss_q);
                                    end else begin
                                        consec_err_q <= consec_err_q + 8'd1;
                                    end
                                end else begin
                                    consec_err_q <= 8'd0;
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            if (i_clear_counters) begin
                word_q    <= 32'd0;
                err_q     <= 32'd0;
                bit_q     <= 32'd0;
                loss_q    <= 32'd0;
                xor_vld_q <= 1'b0;
            end
        end
    end

    assign o_locked          = (state_q == ST_LOCKED);
    assign o_lock_lost       = lost_q;
    assign o_word_count      = word_q;
    assign o_err_word_count  = err_q;
    assign o_bit_err_count   = bit_q;
    assign o_lock_loss_count = loss_q;

endmodule
